// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner.
// Segment codes are active-low {dp,g,f,e,d,c,b,a} with dp held off.
package sevenseg_pkg;

    localparam int NDIG = 4;

    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    // Hex glyphs, indexed by digit value (entry 0 is the rightmost in this literal)
    localparam logic [15:0][7:0] SEG_CODE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
        8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

    typedef enum logic [1:0] {
        SCAN0 = 2'd0,
        SCAN1 = 2'd1,
        SCAN2 = 2'd2,
        SCAN3 = 2'd3
    } scan_t;

endpackage

// File: rtl/sevenseg_scan4_if.sv
// Update handshake between the counter stages and the display driver.
interface sevenseg_scan4_if;

    logic [15:0] upd_data;
    logic [3:0]  upd_dp;
    logic        upd_valid;
    logic        upd_ready;

    modport master (
        output upd_data,
        output upd_dp,
        output upd_valid,
        input  upd_ready
    );

    modport slave (
        input  upd_data,
        input  upd_dp,
        input  upd_valid,
        output upd_ready
    );

endinterface

// File: rtl/sevenseg_scan4_seg_decode.sv
// Hex digit to active-low seven-segment pattern, dp enable folded into bit 7.
module seg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] seg
);

    // Table lookup; dp enable is active-high, segment bus is active-low
    always_comb begin
        seg = {~dp, SEG_CODE[hex][6:0]};
    end

endmodule

// File: rtl/sevenseg_scan4.sv
// Four-digit time-multiplexed seven-segment driver with a double-buffered
// update port. Optional leading-zero blanking: define SEVENSEG_LZB_EN.
module sevenseg_scan4
    import sevenseg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 2
) (
    input  logic             inClk,
    input  logic             rst,
    sevenseg_scan4_if.slave  upd,
    output logic [3:0]       Anode,
    output logic [7:0]       Seven_Seg,
    output logic             frame_tick
);

    localparam int              CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]   CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   BLANK_END = CW'(BLANK_CYC);

    logic [CW-1:0]          cnt;
    scan_t                  state;
    scan_t                  state_nxt;
    logic [1:0]             idx;
    logic                   wrap;
    logic                   boundary;
    logic                   accept;

    logic [NDIG-1:0][3:0]   disp_data;
    logic [NDIG-1:0]        disp_dp;
    logic [NDIG-1:0][3:0]   pend_data;
    logic [NDIG-1:0]        pend_dp;
    logic                   pend_full;

    logic [3:0]             digit;
    logic                   digit_dp;
    logic                   lz_blank;
    logic [7:0]             seg_raw;
    logic [7:0]             seg_nxt;
    logic [3:0]             anode_nxt;

    assign upd.upd_ready = ~pend_full;

    // Slot/frame timing and handshake qualification
    always_comb begin
        idx      = state;
        wrap     = (cnt == CNT_MAX);
        boundary = wrap && (state == SCAN3);
        accept   = upd.upd_valid && ~pend_full;
    end

    // Refresh counter: one full count per digit slot
    always_ff @(posedge inClk or negedge rst) begin
        if (!rst)       cnt <= '0;
        else if (wrap)  cnt <= '0;
        else            cnt <= cnt + 1'b1;
    end

    // Scan state register
    always_ff @(posedge inClk or negedge rst) begin
        if (!rst) state <= SCAN0;
        else      state <= state_nxt;
    end

    // Scan next-state: advance one digit at each slot wrap
    always_comb begin
        state_nxt = state;
        if (wrap) begin
            unique case (state)
                SCAN0: state_nxt = SCAN1;
                SCAN1: state_nxt = SCAN2;
                SCAN2: state_nxt = SCAN3;
                SCAN3: state_nxt = SCAN0;
            endcase
        end
    end

    // Double buffer: accept into pending only when empty; promote on frame boundary.
    // accept and the boundary transfer are mutually exclusive on pend_full, so a
    // value captured in the boundary cycle waits for the next frame.
    always_ff @(posedge inClk or negedge rst) begin
        if (!rst) begin
            disp_data <= '0;
            disp_dp   <= '0;
            pend_data <= '0;
            pend_dp   <= '0;
            pend_full <= 1'b0;
        end else if (boundary && pend_full) begin
            disp_data <= pend_data;
            disp_dp   <= pend_dp;
            pend_full <= 1'b0;
        end else if (accept) begin
            pend_data <= upd.upd_data;
            pend_dp   <= upd.upd_dp;
            pend_full <= 1'b1;
        end
    end

    // Select the digit being scanned and decide leading-zero blanking
    always_comb begin
        digit    = disp_data[idx];
        digit_dp = disp_dp[idx];
`ifdef SEVENSEG_LZB_EN
        unique case (state)
            SCAN3:   lz_blank = (disp_data[3] == 4'h0);
            SCAN2:   lz_blank = (disp_data[3] == 4'h0) && (disp_data[2] == 4'h0);
            SCAN1:   lz_blank = (disp_data[3] == 4'h0) && (disp_data[2] == 4'h0)
                             && (disp_data[1] == 4'h0);
            default: lz_blank = 1'b0;
        endcase
`else
        lz_blank = 1'b0;
`endif
    end

    seg_decode u_seg_decode (
        .hex (digit),
        .dp  (digit_dp),
        .seg (seg_raw)
    );

    // Next output drive: dark during the anti-ghost window, else one digit lit
    always_comb begin
        anode_nxt = ANODE_OFF;
        seg_nxt   = SEG_OFF;
        if (cnt >= BLANK_END) begin
            anode_nxt = ~(4'b0001 << idx);
            seg_nxt   = lz_blank ? (seg_raw | 8'h7F) : seg_raw;
        end
    end

    // Registered outputs, one cycle behind the scan position
    always_ff @(posedge inClk or negedge rst) begin
        if (!rst) begin
            Anode      <= ANODE_OFF;
            Seven_Seg  <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            Anode      <= anode_nxt;
            Seven_Seg  <= seg_nxt;
            frame_tick <= boundary;
        end
    end

endmodule
